ed25519_io_ctrl: RTL and testbench
==================================

# ed25519_io_ctrl

Host-side IO controller inside the ed25519 top. It receives the 768-bit job (scalar, point x, point y) as twelve 64-bit valid/ready beats and presents the operands to the scalar-multiplication core. After the core finishes, it streams the 512-bit result point (x, y) back as eight 64-bit valid/ready beats. The block sits between the top-level ports and the arithmetic core; it owns all host handshake behaviour.

## Interface
- DATA_W, 64, host bus width in bits
- PATN_W, 256, field-element width in bits; IO_CYCLE = PATN_W/DATA_W = 4 (localparam)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous reset, active-low
- i_in_valid  in  1  host input beat valid
- o_in_ready  out  1  block can accept an input beat
- i_in_data  in  DATA_W  input beat
- o_out_valid  out  1  output beat valid
- i_out_ready  in  1  host accepts output beat
- o_out_data  out  DATA_W  output beat
- o_core_start  out  1  one-cycle pulse; operands are valid and stable
- o_core_scalar  out  PATN_W  scalar operand
- o_core_x  out  PATN_W  point x operand
- o_core_y  out  PATN_W  point y operand
- i_core_done  in  1  one-cycle pulse; i_core_x/i_core_y are valid this cycle
- i_core_x  in  PATN_W  result x
- i_core_y  in  PATN_W  result y

## Operation
- Beat transfer happens on a rising edge when valid && ready are both high. Nothing else transfers a beat.
- Input order is MSB-first over a 768-bit word {scalar, x, y}:
  - beat 0 = scalar[255:192]
  - beat 3 = scalar[63:0]
  - beat 4 = x[255:192]
  - beat 11 = y[63:0]
- Output order is MSB-first over {x, y}:
  - beat 0 = x[255:192]
  - beat 7 = y[63:0]
- Input beat counter runs 0..11. Output beat counter runs 0..7. Both clear at the end of each job.
- FSM:
  - RECV: o_in_ready=1. The 12th accepted beat moves the FSM to START.
  - START: o_core_start=1 for exactly one cycle, then WAIT.
  - WAIT: operand registers are frozen. When i_core_done is seen, the FSM captures i_core_x/i_core_y into the 512-bit output shift register and moves to SEND.
  - SEND: o_out_valid=1. Each accepted beat shifts the register left by DATA_W. Acceptance of the 8th beat returns the FSM to RECV.
- i_core_done outside WAIT is ignored.
- i_in_valid while o_in_ready=0 is ignored; no data is latched.
- Reset mid-operation aborts the job. All counters, data and the FSM return to reset values, and the partial job is discarded.

## Timing
- Reset values:
  - o_in_ready=0 while reset is asserted; 1 in the first cycle after release (state RECV).
  - o_out_valid=0, o_out_data=0, o_core_start=0.
  - operand outputs all zero.
- o_core_start rises in the cycle after the edge that accepted beat 11.
- o_out_valid rises in the cycle after i_core_done is sampled.
- o_out_data and o_out_valid stay stable while o_out_valid && !i_out_ready.
- Fully back-to-back beats are supported: at one beat per cycle, 12 input beats take 12 cycles and 8 output beats take 8 cycles.
- Without overlap, minimum job latency excluding the core is: 12 input cycles + 1 START cycle + 1 capture cycle + 8 output cycles.
- All outputs are registered. There is no combinational path from any i_* port to any o_* port.

## Configuration
- ED25519_IO_OVERLAP_EN
  - Defined: o_in_ready is also high during SEND. Beats for the next job fill a separate input buffer.
    - If all 12 beats arrive before SEND ends, o_in_ready drops and the job waits as pending.
    - On the last output beat, a pending job moves the FSM directly to START (next cycle); otherwise the FSM moves to RECV and keeps the partial count.
  - Undefined: o_in_ready=0 from START until the last output beat is accepted. There is a single operand register set.

## Structure
- Package ed25519_pkg holds: DATA_W, PATN_W, IO_CYCLE, the IN_BEATS=12 and OUT_BEATS=8 constants, and the FSM state enum {RECV, START, WAIT, SEND}.
- One natural sub-module: ed25519_beat_shreg, a parameterised width/depth shift register with load and shift-enable. It is instantiated once for input deserialisation and once for output serialisation.

## Test plan
- Basic job: 12 back-to-back beats with scalar=1, x=Gx, y=Gy -> o_core_start pulses exactly once, 1 cycle after beat 11. o_core_x==Gx. Core model returns (Gx,Gy) -> 8 output beats in order, first beat = Gx[255:192].
- Random valid/ready, 50% duty cycle on both sides -> identical operands and output stream. o_out_data never changes while valid && !ready.
- Spurious inputs: i_in_valid=1 during WAIT with data 0xDEAD... and i_core_done pulsed during RECV -> no beat latched, no state change.
- Reset asserted after beat 5 -> all outputs at reset values. A fresh 12-beat job afterwards completes correctly.
- Two jobs back to back with ED25519_IO_OVERLAP_EN defined -> second job's beats are accepted during SEND, and o_core_start follows 1 cycle after the first job's last output beat. Without the macro, o_in_ready=0 throughout SEND.
- Output stall: i_out_ready=0 for 20 cycles after the first output beat -> beat 1 is held, and the subsequent order and values are unchanged.

Source files
------------

// File: rtl/ed25519_pkg.sv
// ed25519_pkg
// Shared constants and types for the ed25519 host IO controller.
//   DATA_W    : host bus width (one beat)
//   PATN_W    : field-element width
//   IO_CYCLE  : beats per field element
//   IN_BEATS  : beats per job ({scalar, x, y})
//   OUT_BEATS : beats per result ({x, y})
//   io_state_e: controller FSM states
package ed25519_pkg;

    localparam int DATA_W    = 64;
    localparam int PATN_W    = 256;
    localparam int IO_CYCLE  = PATN_W / DATA_W;
    localparam int IN_BEATS  = 3 * IO_CYCLE;
    localparam int OUT_BEATS = 2 * IO_CYCLE;

    localparam int IN_W      = IN_BEATS * DATA_W;
    localparam int OUT_W     = OUT_BEATS * DATA_W;
    localparam int IN_CNT_W  = $clog2(IN_BEATS);
    localparam int OUT_CNT_W = $clog2(OUT_BEATS);

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } io_state_e;

endpackage

// File: rtl/ed25519_beat_shreg.sv
// ed25519_beat_shreg
// Beat-wide shift register, MSB-first. A load replaces the whole word; a
// shift moves everything up by one beat and inserts shift_in at the bottom,
// so the oldest beat sits in the top WIDTH bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : parallel load of load_data (wins over shift_en)
//   load_data  : WIDTH*DEPTH word to load
//   shift_en   : shift left by WIDTH
//   shift_in   : beat inserted at the LSB end on a shift
//   data       : current register contents
module ed25519_beat_shreg
    import ed25519_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = IO_CYCLE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WIDTH*DEPTH-1:0] load_data,
    input  logic                   shift_en,
    input  logic [WIDTH-1:0]       shift_in,
    output logic [WIDTH*DEPTH-1:0] data
);

    // NOTE: this datapath register is reset on purpose; its contents drive
    // outputs whose zero value after reset is visible to the host and core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_en) begin
            data <= {data[WIDTH*DEPTH-WIDTH-1:0], shift_in};
        end
    end

endmodule

// File: rtl/ed25519_io_ctrl.sv
// ed25519_io_ctrl
// Host-side IO controller: deserialises a 12-beat job {scalar, x, y} into
// operands for the scalar-multiplication core, pulses o_core_start, waits for
// i_core_done, then serialises the result {x, y} as 8 beats. All beats are
// MSB-first; every output is a register.
//   i_in_valid / o_in_ready / i_in_data    : host input beats
//   o_out_valid / i_out_ready / o_out_data : host output beats
//   o_core_start, o_core_scalar/x/y        : operands to the core
//   i_core_done, i_core_x/y                : result from the core
// Build option ED25519_IO_OVERLAP_EN: accept the next job's beats during SEND
// into the input buffer while a separate operand register holds the current
// job; a fully buffered job starts right after the last output beat.
module ed25519_io_ctrl
    import ed25519_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_core_start,
    output logic [PATN_W-1:0] o_core_scalar,
    output logic [PATN_W-1:0] o_core_x,
    output logic [PATN_W-1:0] o_core_y,
    input  logic              i_core_done,
    input  logic [PATN_W-1:0] i_core_x,
    input  logic [PATN_W-1:0] i_core_y
);

    io_state_e              state;
    logic [IN_CNT_W-1:0]    in_cnt;
    logic [OUT_CNT_W-1:0]   out_cnt;

    logic                   in_fire;
    logic                   out_fire;
    logic                   in_last;
    logic                   out_last;
    logic                   out_load;

    logic [IN_W-1:0]        in_shreg;
    logic [OUT_W-1:0]       out_shreg;
    logic [OUT_W-DATA_W-1:0] out_tail_unused;

    assign in_fire  = i_in_valid & o_in_ready;
    assign out_fire = o_out_valid & i_out_ready;
    assign in_last  = (in_cnt == IN_CNT_W'(IN_BEATS - 1));
    assign out_last = (out_cnt == OUT_CNT_W'(OUT_BEATS - 1));
    // Completion is only honoured while waiting for it.
    assign out_load = (state == WAIT) & i_core_done;

    ed25519_beat_shreg #(
        .WIDTH (DATA_W),
        .DEPTH (IN_BEATS)
    ) u_in_shreg (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (in_fire),
        .shift_in  (i_in_data),
        .data      (in_shreg)
    );

    ed25519_beat_shreg #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_BEATS)
    ) u_out_shreg (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (out_load),
        .load_data ({i_core_x, i_core_y}),
        .shift_en  (out_fire),
        .shift_in  ('0),
        .data      (out_shreg)
    );

    // Only the top beat leaves the block; the rest reaches it by shifting.
    assign {o_out_data, out_tail_unused} = out_shreg;

`ifdef ED25519_IO_OVERLAP_EN
    logic            pending;
    logic            op_load;
    logic [IN_W-1:0] op_load_data;
    logic [IN_W-1:0] op_q;

    // NOTE: every signal written here gets a default first so no latch is
    // inferred when none of the conditions below hold.
    always_comb begin
        op_load = 1'b0;
        if (state == RECV && in_fire && in_last) begin
            op_load = 1'b1;
        end
        if (state == SEND && out_fire && out_last && (pending || (in_fire && in_last))) begin
            op_load = 1'b1;
        end
    end

    // A pending job is already whole in the buffer; otherwise the final beat
    // is arriving this cycle and is merged in on the way to the operands.
    assign op_load_data = pending ? in_shreg : {in_shreg[IN_W-DATA_W-1:0], i_in_data};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q <= '0;
        end else if (op_load) begin
            op_q <= op_load_data;
        end
    end

    assign {o_core_scalar, o_core_x, o_core_y} = op_q;
`else
    // Single register set: the input buffer is frozen from START until the
    // last output beat, so it doubles as the operand register.
    assign {o_core_scalar, o_core_x, o_core_y} = in_shreg;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= RECV;
            in_cnt       <= '0;
            out_cnt      <= '0;
            o_in_ready   <= 1'b0;
            o_core_start <= 1'b0;
            o_out_valid  <= 1'b0;
`ifdef ED25519_IO_OVERLAP_EN
            pending      <= 1'b0;
`endif
        end else begin
            o_core_start <= 1'b0;
            case (state)
                RECV: begin
                    o_in_ready <= 1'b1;
                    if (in_fire) begin
                        if (in_last) begin
                            in_cnt       <= '0;
                            o_in_ready   <= 1'b0;
                            o_core_start <= 1'b1;
                            state        <= START;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end

                START: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (i_core_done) begin
                        o_out_valid <= 1'b1;
                        state       <= SEND;
`ifdef ED25519_IO_OVERLAP_EN
                        o_in_ready  <= 1'b1;
`endif
                    end
                end

                SEND: begin
`ifdef ED25519_IO_OVERLAP_EN
                    if (in_fire) begin
                        if (in_last) begin
                            in_cnt     <= '0;
                            pending    <= 1'b1;
                            o_in_ready <= 1'b0;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
`endif
                    if (out_fire) begin
                        if (out_last) begin
                            out_cnt     <= '0;
                            o_out_valid <= 1'b0;
`ifdef ED25519_IO_OVERLAP_EN
                            if (pending || (in_fire && in_last)) begin
                                pending      <= 1'b0;
                                o_in_ready   <= 1'b0;
                                o_core_start <= 1'b1;
                                state        <= START;
                            end else begin
                                // Partial next-job count is kept.
                                o_in_ready <= 1'b1;
                                state      <= RECV;
                            end
`else
                            o_in_ready <= 1'b1;
                            state      <= RECV;
`endif
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= RECV;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ed25519_io_ctrl.sv
// tb_ed25519_io_ctrl
// Directed bench for ed25519_io_ctrl: reset state, basic G job, random
// handshakes, spurious inputs, output stall, mid-job reset and (when
// ED25519_IO_OVERLAP_EN is defined) overlapped back-to-back jobs.
module tb_ed25519_io_ctrl;
    import ed25519_pkg::*;

    typedef logic [767:0] vec_t;

    localparam logic [255:0] GX = 256'h216936D3_CD6E53FE_C0A4E231_FDD6DC5C_692CC760_9525A7B2_C9562D60_8F25D51A;
    localparam logic [255:0] GY = 256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_data;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [DATA_W-1:0] o_out_data;
    logic              o_core_start;
    logic [PATN_W-1:0] o_core_scalar;
    logic [PATN_W-1:0] o_core_x;
    logic [PATN_W-1:0] o_core_y;
    logic              i_core_done;
    logic [PATN_W-1:0] i_core_x;
    logic [PATN_W-1:0] i_core_y;

    int n_pass  = 0;
    int n_total = 0;

    ed25519_io_ctrl dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_in_data     (i_in_data),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_data    (o_out_data),
        .o_core_start  (o_core_start),
        .o_core_scalar (o_core_scalar),
        .o_core_x      (o_core_x),
        .o_core_y      (o_core_y),
        .i_core_done   (i_core_done),
        .i_core_x      (i_core_x),
        .i_core_y      (i_core_y)
    );

    always #5 i_clk = ~i_clk;

    // Four distinct 64-bit words from one seed, so beat order errors show.
    function automatic logic [255:0] pat(input logic [63:0] s);
        return {s, s ^ 64'hFFFF_0000_FFFF_0000, ~s, s + 64'h0101_0101_0101_0101};
    endfunction

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Every step leaves the bench 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic push_job(input vec_t job, input bit rnd, input int nbeats, output int cycles);
        int  i;
        bit  acc;
        i      = 0;
        cycles = 0;
        while (i < nbeats && cycles < 1000) begin
            i_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_in_data  = job[767 - 64*i -: 64];
            acc        = i_in_valid && o_in_ready;
            step(1);
            cycles++;
            if (acc) i++;
        end
        i_in_valid = 1'b0;
        i_in_data  = '0;
        check("push_beats", vec_t'(i), vec_t'(nbeats));
    endtask

    task automatic core_respond(input logic [255:0] rx, input logic [255:0] ry, input int dly);
        step(dly);
        check("valid_before_done", vec_t'(o_out_valid), vec_t'(1'b0));
        i_core_done = 1'b1;
        i_core_x    = rx;
        i_core_y    = ry;
        step(1);
        i_core_done = 1'b0;
        i_core_x    = {4{64'hBAD0_BAD0_BAD0_BAD0}};
        i_core_y    = {4{64'h0BAD_0BAD_0BAD_0BAD}};
        check("valid_after_done", vec_t'(o_out_valid), vec_t'(1'b1));
    endtask

    task automatic run_send(input logic [511:0] exp, input bit rnd, input int stall,
                            input bit feed, input vec_t nxt, output int fed, output int cycles);
        int          j;
        int          hold;
        int          viol;
        int          rdy;
        bit          acc_out;
        bit          acc_in;
        logic        prev_stall;
        logic [63:0] prev_data;
        logic [511:0] sh;
        j = 0; hold = 0; viol = 0; rdy = 0; fed = 0; cycles = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        sh         = exp;
        while (j < 8 && cycles < 500) begin
            if (prev_stall && (o_out_valid !== 1'b1 || o_out_data !== prev_data)) viol++;
            if (o_out_valid && o_in_ready) rdy++;
            if (rnd) begin
                i_out_ready = 1'($urandom_range(0, 1));
            end else begin
                i_out_ready = (hold == 0);
                if (hold > 0) hold--;
            end
            if (feed && fed < 12) begin
                i_in_valid = 1'b1;
                i_in_data  = nxt[767 - 64*fed -: 64];
            end else begin
                i_in_valid = 1'b0;
            end
            acc_out = o_out_valid && i_out_ready;
            acc_in  = i_in_valid && o_in_ready;
            if (acc_out) check($sformatf("out_beat%0d", j), vec_t'(o_out_data), vec_t'(sh[511 -: 64]));
            prev_stall = o_out_valid && !i_out_ready;
            prev_data  = o_out_data;
            step(1);
            cycles++;
            if (acc_in) fed++;
            if (acc_out) begin
                if (j == 0) hold = stall;
                sh = sh << 64;
                j++;
            end
        end
        i_out_ready = 1'b0;
        i_in_valid  = 1'b0;
        check("send_beats", vec_t'(j), vec_t'(8));
        check("out_stable_in_stall", vec_t'(viol), vec_t'(0));
`ifdef ED25519_IO_OVERLAP_EN
        if (!feed) check("in_ready_in_send", vec_t'(rdy), vec_t'(cycles));
`else
        check("in_ready_in_send", vec_t'(rdy), vec_t'(0));
`endif
        check("valid_low_after_send", vec_t'(o_out_valid), vec_t'(1'b0));
    endtask

    initial begin
        int           cyc;
        int           fed;
        int           seen;
        vec_t         job;
        logic [255:0] rx;
        logic [255:0] ry;

        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_out_ready = 1'b0;
        i_core_done = 1'b0;
        i_core_x    = '0;
        i_core_y    = '0;
        step(3);

        // Reset state
        check("rst_in_ready",  vec_t'(o_in_ready),   vec_t'(1'b0));
        check("rst_out_valid", vec_t'(o_out_valid),  vec_t'(1'b0));
        check("rst_out_data",  vec_t'(o_out_data),   vec_t'(0));
        check("rst_start",     vec_t'(o_core_start), vec_t'(1'b0));
        check("rst_operands",  {o_core_scalar, o_core_x, o_core_y}, vec_t'(0));
        i_rst_n = 1'b1;
        step(1);
        check("ready_after_rst", vec_t'(o_in_ready), vec_t'(1'b1));

        // Basic job: scalar=1, (Gx, Gy), back-to-back
        job = {256'd1, GX, GY};
        push_job(job, 1'b0, 12, cyc);
        check("in_b2b_cycles", vec_t'(cyc), vec_t'(12));
        check("start_pulse",   vec_t'(o_core_start), vec_t'(1'b1));
        check("ready_low_start", vec_t'(o_in_ready), vec_t'(1'b0));
        check("op_scalar",     vec_t'(o_core_scalar), vec_t'(256'd1));
        check("op_x",          vec_t'(o_core_x), vec_t'(GX));
        check("op_y",          vec_t'(o_core_y), vec_t'(GY));
        step(1);
        check("start_one_cycle", vec_t'(o_core_start), vec_t'(1'b0));
        core_respond(GX, GY, 3);
        check("first_beat_gx_hi", vec_t'(o_out_data), vec_t'(64'h216936D3CD6E53FE));
        run_send({GX, GY}, 1'b0, 0, 1'b0, '0, fed, cyc);
        check("out_b2b_cycles", vec_t'(cyc), vec_t'(8));
        check("ready_after_job", vec_t'(o_in_ready), vec_t'(1'b1));

        // Random 50% handshakes on both sides
        job = {pat(64'h0123_4567_89AB_CDEF), pat(64'h1357_9BDF_0246_8ACE), pat(64'hA5A5_5A5A_C3C3_3C3C)};
        rx  = pat(64'hFEDC_BA98_7654_3210);
        ry  = pat(64'h0F1E_2D3C_4B5A_6978);
        push_job(job, 1'b1, 12, cyc);
        check("rnd_start", vec_t'(o_core_start), vec_t'(1'b1));
        check("rnd_operands", {o_core_scalar, o_core_x, o_core_y}, job);
        core_respond(rx, ry, 2);
        run_send({rx, ry}, 1'b1, 0, 1'b0, '0, fed, cyc);

        // Spurious input beats during START/WAIT, spurious done during RECV
        job = {pat(64'h5555_0000_1234_0001), pat(64'h6666_1111_2345_0002), pat(64'h7777_2222_3456_0003)};
        rx  = pat(64'h1111_2222_3333_4444);
        ry  = pat(64'h9999_AAAA_BBBB_CCCC);
        push_job(job, 1'b0, 12, cyc);
        seen = 0;
        repeat (5) begin
            i_in_valid = 1'b1;
            i_in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
            if (o_in_ready) seen++;
            step(1);
        end
        i_in_valid = 1'b0;
        check("wait_ready_low",  vec_t'(seen), vec_t'(0));
        check("wait_ops_frozen", {o_core_scalar, o_core_x, o_core_y}, job);
        check("wait_no_start",   vec_t'(o_core_start), vec_t'(1'b0));
        core_respond(rx, ry, 1);
        run_send({rx, ry}, 1'b0, 0, 1'b0, '0, fed, cyc);
        i_core_done = 1'b1;
        i_core_x    = {4{64'hDEAD_DEAD_DEAD_DEAD}};
        i_core_y    = {4{64'hDEAD_DEAD_DEAD_DEAD}};
        step(1);
        i_core_done = 1'b0;
        step(1);
        check("recv_done_no_valid", vec_t'(o_out_valid), vec_t'(1'b0));
        check("recv_done_no_data",  vec_t'(o_out_data),  vec_t'(0));
        check("recv_done_ready",    vec_t'(o_in_ready),  vec_t'(1'b1));

        // Output stall of 20 cycles after the first beat
        job = {pat(64'h2468_ACE0_1357_9BDF), pat(64'hC0DE_C0DE_0000_FFFF), pat(64'h0000_0001_8000_0000)};
        rx  = pat(64'h8765_4321_0FED_CBA9);
        ry  = pat(64'h3141_5926_5358_9793);
        push_job(job, 1'b0, 12, cyc);
        check("stall_operands", {o_core_scalar, o_core_x, o_core_y}, job);
        core_respond(rx, ry, 4);
        run_send({rx, ry}, 1'b0, 20, 1'b0, '0, fed, cyc);
        check("stall_cycles", vec_t'(cyc), vec_t'(28));

        // Reset after beat 5 aborts the job
        job = {pat(64'hABCD_0000_0000_0001), pat(64'hABCD_0000_0000_0002), pat(64'hABCD_0000_0000_0003)};
        push_job(job, 1'b0, 6, cyc);
        i_rst_n = 1'b0;
        #1;
        check("abort_in_ready",  vec_t'(o_in_ready),   vec_t'(1'b0));
        check("abort_out_valid", vec_t'(o_out_valid),  vec_t'(1'b0));
        check("abort_start",     vec_t'(o_core_start), vec_t'(1'b0));
        check("abort_operands",  {o_core_scalar, o_core_x, o_core_y}, vec_t'(0));
        step(2);
        i_rst_n = 1'b1;
        step(1);
        check("abort_ready_back", vec_t'(o_in_ready), vec_t'(1'b1));
        job = {pat(64'h7E57_0000_AAAA_5555), pat(64'h7E57_1111_BBBB_6666), pat(64'h7E57_2222_CCCC_7777)};
        rx  = pat(64'h0000_FFFF_1234_5678);
        ry  = pat(64'hFFFF_0000_8765_4321);
        push_job(job, 1'b1, 12, cyc);
        check("fresh_start",    vec_t'(o_core_start), vec_t'(1'b1));
        check("fresh_operands", {o_core_scalar, o_core_x, o_core_y}, job);
        core_respond(rx, ry, 2);
        run_send({rx, ry}, 1'b0, 0, 1'b0, '0, fed, cyc);

`ifdef ED25519_IO_OVERLAP_EN
        // Overlapped jobs: job B fully buffered during job A's SEND
        job = {pat(64'h0A0A_0000_0000_0001), pat(64'h0A0A_0000_0000_0002), pat(64'h0A0A_0000_0000_0003)};
        push_job(job, 1'b0, 12, cyc);
        core_respond(GX, GY, 2);
        job = {pat(64'h0B0B_0000_0000_0001), pat(64'h0B0B_0000_0000_0002), pat(64'h0B0B_0000_0000_0003)};
        run_send({GX, GY}, 1'b0, 20, 1'b1, job, fed, cyc);
        check("ovl_fed",       vec_t'(fed), vec_t'(12));
        check("ovl_start",     vec_t'(o_core_start), vec_t'(1'b1));
        check("ovl_operands",  {o_core_scalar, o_core_x, o_core_y}, job);
        step(1);
        check("ovl_start_once", vec_t'(o_core_start), vec_t'(1'b0));
        rx = pat(64'h5A5A_0000_0000_0001);
        ry = pat(64'h5A5A_0000_0000_0002);
        core_respond(rx, ry, 2);
        run_send({rx, ry}, 1'b0, 0, 1'b0, '0, fed, cyc);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
